// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_ctrl_pkg                                            |
// | Brief   : Shared operation, word and state types for branch_ctrl.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package branch_ctrl_pkg;

  typedef logic [63:0] dword_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLT  = 3'd3,
    OP_BGE  = 3'd4,
    OP_BLTU = 3'd5,
    OP_BGEU = 3'd6
  } oper_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  function automatic logic is_branch_op(oper_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_cmp                                                 |
// | Brief   : Combinational branch condition evaluation.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module branch_cmp
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  oper_t             op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic              is_branch_o,
  output logic              taken_o
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (rs1_i == rs2_i);
  assign w_lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign w_ltu = (rs1_i < rs2_i);

  assign is_branch_o = is_branch_op(op_i);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = w_eq;
      OP_BNE:  taken_o = ~w_eq;
      OP_BLT:  taken_o = w_lt;
      OP_BGE:  taken_o = ~w_lt;
      OP_BLTU: taken_o = w_ltu;
      OP_BGEU: taken_o = ~w_ltu;
      default: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_ctrl                                                |
// | Brief   : Execute-stage branch sequencer: evaluate, redirect, flush. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              req_valid,
  output logic              req_ready,
  input  oper_t             req_op,
  input  logic [XLEN-1:0]   req_pc,
  input  dword_t            req_imm,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              done_valid,
  output logic              done_taken,
  output logic              exc_valid,
  output logic [XLEN-1:0]   exc_tval,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_taken
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state_q;
  logic              req_ready_q;
  logic              redirect_valid_q;
  logic              flush_q;
  logic              done_valid_q;
  logic              done_taken_q;
  logic              exc_valid_q;
  logic              go_redirect_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [XLEN-1:0]   exc_tval_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_tk_q, perf_tk_d;

  logic              w_is_branch;
  logic              w_taken;
  logic [XLEN-1:0]   w_offset;
  logic [XLEN-1:0]   w_target;

  // The condition is resolved on the incoming operands so the registered
  // outcome is already visible during the EVAL cycle.
  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .op_i        (req_op),
    .rs1_i       (req_rs1),
    .rs2_i       (req_rs2),
    .is_branch_o (w_is_branch),
    .taken_o     (w_taken)
  );

  assign w_offset = XLEN'($signed({req_imm, 1'b0}));
  assign w_target = req_pc + w_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      done_valid_q     <= 1'b0;
      done_taken_q     <= 1'b0;
      exc_valid_q      <= 1'b0;
      go_redirect_q    <= 1'b0;
      redirect_pc_q    <= '0;
      exc_tval_q       <= '0;
      cnt_q            <= '0;
    end else if (kill) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      done_valid_q     <= 1'b0;
      exc_valid_q      <= 1'b0;
      go_redirect_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_EVAL;
            req_ready_q <= 1'b0;
            if (w_is_branch) begin
              if (!w_taken) begin
                done_valid_q <= 1'b1;
                done_taken_q <= 1'b0;
              end else if (w_target[1]) begin
                exc_valid_q <= 1'b1;
                exc_tval_q  <= w_target;
              end else begin
                go_redirect_q <= 1'b1;
                redirect_pc_q <= w_target;
              end
            end
          end
        end
        ST_EVAL: begin
          done_valid_q  <= 1'b0;
          exc_valid_q   <= 1'b0;
          go_redirect_q <= 1'b0;
          if (go_redirect_q) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= ST_FLUSH;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b1;
            cnt_q            <= C_CNT_LOAD;
            // Completion coincides with the last flush cycle.
            if (FLUSH_CYCLES == 1) begin
              done_valid_q <= 1'b1;
              done_taken_q <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            flush_q      <= 1'b0;
            done_valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              done_valid_q <= 1'b1;
              done_taken_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign redirect_valid = redirect_valid_q & ~kill;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q & ~kill;
  assign done_valid     = done_valid_q & ~kill;
  assign done_taken     = done_taken_q;
  assign exc_valid      = exc_valid_q & ~kill;
  assign exc_tval       = exc_tval_q;

  // Counters follow the masked pulses, so killed completions never count.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_tk_d = perf_tk_q;
    if (done_valid || exc_valid) begin
      perf_br_d = perf_br_q + PERF_W'(1);
    end
    if ((done_valid && done_taken) || exc_valid) begin
      perf_tk_d = perf_tk_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_tk_q <= perf_tk_d;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_taken    = perf_tk_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_branch_ctrl                                             |
// | Brief   : Directed plus random bench for branch_ctrl with a model.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN = 64;
  localparam int FC   = 2;
  localparam int PW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            kill = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  oper_t           req_op = OP_NOP;
  logic [XLEN-1:0] req_pc = '0;
  dword_t          req_imm = '0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs2 = '0;
  logic            redirect_valid;
  logic            redirect_ready = 1'b0;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            done_valid;
  logic            done_taken;
  logic            exc_valid;
  logic [XLEN-1:0] exc_tval;
  logic [PW-1:0]   perf_branches;
  logic [PW-1:0]   perf_taken;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_br = '0;
  logic [PW-1:0] exp_tk = '0;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pc(req_pc), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .done_valid(done_valid), .done_taken(done_taken),
    .exc_valid(exc_valid), .exc_tval(exc_tval),
    .perf_branches(perf_branches), .perf_taken(perf_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_taken(oper_t op, logic [63:0] a, logic [63:0] b);
    longint sa = a;
    longint sb = b;
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return a < b;
      OP_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_idle_quiet(input string tag);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_rv"}, redirect_valid, 1'b0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_done"}, done_valid, 1'b0);
    chk({tag, "_exc"}, exc_valid, 1'b0);
    chk({tag, "_perf_br"}, perf_branches, exp_br);
    chk({tag, "_perf_tk"}, perf_taken, exp_tk);
  endtask

  // One branch from acceptance to return to IDLE; caller is in an IDLE cycle.
  task automatic issue(input oper_t op, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] a, input logic [63:0] b,
                       input int rwait, input bit kill_hs);
    bit is_br, tk;
    logic [63:0] tgt;
    is_br = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    tk    = is_br && model_taken(op, a, b);
    tgt   = pc + imm * 2;

    chk("accept_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_pc = pc; req_imm = imm; req_rs1 = a; req_rs2 = b;
    tick();
    req_valid = 1'b0;
    req_op  = oper_t'($urandom_range(0, 6));
    req_pc  = {$urandom, $urandom};
    req_imm = {$urandom, $urandom};
    req_rs1 = {$urandom, $urandom};
    req_rs2 = {$urandom, $urandom};

    chk("eval_ready", req_ready, 1'b0);
    chk("eval_rv", redirect_valid, 1'b0);
    if (!is_br) begin
      chk("nop_done", done_valid, 1'b0);
      chk("nop_exc", exc_valid, 1'b0);
    end else if (!tk) begin
      chk("nt_done", done_valid, 1'b1);
      chk("nt_taken", done_taken, 1'b0);
      chk("nt_exc", exc_valid, 1'b0);
      exp_br++;
    end else if (tgt[1]) begin
      chk("exc_valid", exc_valid, 1'b1);
      chk("exc_tval", exc_tval, tgt);
      chk("exc_done", done_valid, 1'b0);
      exp_br++; exp_tk++;
    end else begin
      chk("tk_eval_done", done_valid, 1'b0);
      chk("tk_eval_exc", exc_valid, 1'b0);
    end
    tick();

    if (is_br && tk && !tgt[1]) begin
      for (int i = 0; i <= rwait; i++) begin
        redirect_ready = (i == rwait);
        kill = kill_hs && (i == rwait);
        #1;
        chk("rd_valid", redirect_valid, !kill);
        chk("rd_pc", redirect_pc, tgt);
        chk("rd_flush", flush, 1'b0);
        tick();
      end
      redirect_ready = 1'b0;
      kill = 1'b0;
      if (!kill_hs) begin
        for (int j = 1; j <= FC; j++) begin
          chk("fl_flush", flush, 1'b1);
          chk("fl_rv", redirect_valid, 1'b0);
          chk("fl_done", done_valid, j == FC);
          if (j == FC) chk("fl_taken", done_taken, 1'b1);
          tick();
        end
        exp_br++; exp_tk++;
      end
    end
    chk_idle_quiet("idle");
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_done", done_valid, 1'b0);
    chk("rst_dtaken", done_taken, 1'b0);
    chk("rst_exc", exc_valid, 1'b0);
    chk("rst_rpc", redirect_pc, 64'h0);
    chk("rst_tval", exc_tval, 64'h0);
    chk("rst_pbr", perf_branches, 32'h0);
    chk("rst_ptk", perf_taken, 32'h0);

    // Directed steps
    issue(OP_BEQ, 64'h1000, 64'h8, 64'd5, 64'd6, 0, 1'b0);
    chk("beq_pbr", perf_branches, 32'd1);
    chk("beq_ptk", perf_taken, 32'd0);
    issue(OP_BLT, 64'h1000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3, 1'b0);
    issue(OP_BLTU, 64'h1000, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
    issue(OP_BNE, 64'hFFFF_FFFF_FFFF_FFFC, 64'd2, 64'd1, 64'd2, 1, 1'b0);
    issue(OP_BNE, 64'h1000, 64'd1, 64'd1, 64'd2, 0, 1'b0);
    issue(OP_BEQ, 64'h2000, 64'h40, 64'd7, 64'd7, 1, 1'b1);
    issue(OP_NOP, 64'h3000, 64'h4, 64'd0, 64'd0, 0, 1'b0);
    issue(OP_BGE, 64'h4000, 64'h4, 64'd1, 64'd9, 0, 1'b0);
    issue(OP_BGEU, 64'h4004, 64'h4, 64'd1, 64'd9, 0, 1'b0);
    issue(OP_BLT, 64'h5000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 64'd2, 0, 1'b0);

    // Random stimulus against the model
    for (int n = 0; n < 150; n++) begin
      logic [63:0] a, b, pc, imm;
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = -a;
      pc  = {$urandom, $urandom} & ~64'h1;
      imm = 64'($signed(12'($urandom)));
      issue(oper_t'($urandom_range(0, 7)), pc, imm, a, b,
            $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    // Reset while a redirect is pending
    req_valid = 1'b1; req_op = OP_BEQ; req_pc = 64'h8000; req_imm = 64'h2;
    req_rs1 = 64'd3; req_rs2 = 64'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_rv", redirect_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_br = '0; exp_tk = '0;
    chk_idle_quiet("midrst");
    issue(OP_BNE, 64'h100, 64'h2, 64'd4, 64'd4, 0, 1'b0);
    chk("post_rst_pbr", perf_branches, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
